// File: rtl/ddr3_iod_dly_ctrl.sv
// ddr3_iod_dly_ctrl: sequences LOAD / MOVE / DIRECTION pulses for one DDR3 PHY
// IOD delay line from LOAD / INC-by-N / DEC-by-N commands, keeping a shadow
// tap count and a sticky out-of-range flag.
module ddr3_iod_dly_ctrl #(
    parameter int TAP_W       = 8,
    parameter int INIT_TAP    = 1,
    parameter int MAX_TAP     = 127,
    parameter int LOAD_CYCLES = 2,
    parameter int MOVE_GAP    = 3
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_STEPS,
    output logic             CMD_DONE,
    output logic             CMD_ERR,
    output logic [TAP_W-1:0] TAP_COUNT,
    output logic             OOR_ERR,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int CNT_W = 8;
    localparam logic [TAP_W-1:0] INIT_TAP_C = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] MAX_TAP_C  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] ZERO_TAP   = {TAP_W{1'b0}};
    localparam logic [TAP_W-1:0] ONE_TAP    = TAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MOVE_GAP - 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DIR_SETUP = 3'd2,
        ST_MOVE      = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t           state_r;
    logic             ready_r;
    logic             done_r;
    logic             err_r;
    logic             oor_r;
    logic             load_r;
    logic             move_r;
    logic             dir_r;
    logic [TAP_W-1:0] tap_r;
    logic [TAP_W-1:0] rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic [TAP_W-1:0] tap_step_s;

    // True when one more step in direction dir would leave the legal tap range.
    function automatic logic at_limit(input logic dir, input logic [TAP_W-1:0] tap);
        at_limit = dir ? (tap == MAX_TAP_C) : (tap == ZERO_TAP);
    endfunction

    // Tap value after one successful step in the current direction.
    always_comb begin
        tap_step_s = tap_r;
        if (dir_r) begin
            tap_step_s = tap_r + ONE_TAP;
        end else begin
            tap_step_s = tap_r - ONE_TAP;
        end
    end

    // Command sequencer: state, counters, shadow tap and all registered outputs.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            oor_r   <= 1'b0;
            load_r  <= 1'b0;
            move_r  <= 1'b0;
            dir_r   <= 1'b0;
            tap_r   <= INIT_TAP_C;
            rem_r   <= ZERO_TAP;
            cnt_r   <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            load_r <= 1'b0;
            move_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (CMD_VALID && ready_r) begin
                        ready_r <= 1'b0;
                        case (CMD_OP)
                            OP_LOAD: begin
                                state_r <= ST_LOAD;
                                load_r  <= 1'b1;
                                cnt_r   <= CNT_ZERO;
                            end
                            OP_INC, OP_DEC: begin
                                if (CMD_STEPS == ZERO_TAP) begin
                                    state_r <= ST_DONE;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_DIR_SETUP;
                                    dir_r   <= (CMD_OP == OP_INC);
                                    rem_r   <= CMD_STEPS;
                                end
                            end
                            default: begin
                                // reserved op completes immediately with an error
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                err_r   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (cnt_r == LOAD_LAST) begin
                        tap_r   <= INIT_TAP_C;
                        oor_r   <= 1'b0;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        load_r <= 1'b1;
                    end
                end
                ST_DIR_SETUP: begin
                    // saturation pre-check for the first move
                    if (at_limit(dir_r, tap_r)) begin
                        oor_r   <= 1'b1;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                    end else begin
                        move_r  <= 1'b1;
                        state_r <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    state_r <= ST_GAP;
                    cnt_r   <= CNT_ZERO;
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        if (DELAY_LINE_OUT_OF_RANGE) begin
                            oor_r   <= 1'b1;
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            tap_r <= tap_step_s;
                            rem_r <= rem_r - ONE_TAP;
                            if (rem_r == ONE_TAP) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else if (at_limit(dir_r, tap_step_s)) begin
                                // pre-check on the updated tap before the next move
                                oor_r   <= 1'b1;
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                err_r   <= 1'b1;
                            end else begin
                                move_r  <= 1'b1;
                                state_r <= ST_MOVE;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign CMD_READY            = ready_r;
    assign CMD_DONE             = done_r;
    assign CMD_ERR              = err_r;
    assign TAP_COUNT            = tap_r;
    assign OOR_ERR              = oor_r;
    assign DELAY_LINE_LOAD      = load_r;
    assign DELAY_LINE_MOVE      = move_r;
    assign DELAY_LINE_DIRECTION = dir_r;

endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// Self-checking bench for ddr3_iod_dly_ctrl: directed scenarios followed by
// random commands, each predicted from the command rules by a small model.
module tb_ddr3_iod_dly_ctrl;

    localparam int TAP_W       = 8;
    localparam int INIT_TAP    = 1;
    localparam int MAX_TAP     = 127;
    localparam int LOAD_CYCLES = 2;
    localparam int MOVE_GAP    = 3;
    localparam int PER         = 1 + MOVE_GAP;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [TAP_W-1:0] steps = 8'd0;
    logic             oor_in = 1'b0;
    logic             ready, done, err, oor_err, dl_load, dl_move, dl_dir;
    logic [TAP_W-1:0] tap;

    int total = 0;
    int bad   = 0;
    int m_tap = INIT_TAP;
    int m_oor = 0;
    int m_dir = 0;

    ddr3_iod_dly_ctrl #(
        .TAP_W(TAP_W), .INIT_TAP(INIT_TAP), .MAX_TAP(MAX_TAP),
        .LOAD_CYCLES(LOAD_CYCLES), .MOVE_GAP(MOVE_GAP)
    ) dut (
        .FAB_CLK(clk),
        .SYNC_RST(rst),
        .CMD_VALID(valid),
        .CMD_READY(ready),
        .CMD_OP(op),
        .CMD_STEPS(steps),
        .CMD_DONE(done),
        .CMD_ERR(err),
        .TAP_COUNT(tap),
        .OOR_ERR(oor_err),
        .DELAY_LINE_LOAD(dl_load),
        .DELAY_LINE_MOVE(dl_move),
        .DELAY_LINE_DIRECTION(dl_dir),
        .DELAY_LINE_OUT_OF_RANGE(oor_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command (accepted at the next edge) and check every cycle up to
    // and including the cycle after CMD_DONE. oor_k>0 raises OUT_OF_RANGE during
    // the whole gap following the oor_k-th move.
    task automatic run_cmd(input int c_op, input int c_steps, input int oor_k);
        int moves, allowed, exp_done, exp_err, nt, no, nd;
        int exp_mv, exp_ld;
        bit inc;
        moves = 0; nt = m_tap; no = m_oor; nd = m_dir; exp_err = 0;
        if (c_op == 0) begin
            exp_done = LOAD_CYCLES + 1; nt = INIT_TAP; no = 0;
        end else if (c_op == 3) begin
            exp_done = 1; exp_err = 1;
        end else if (c_steps == 0) begin
            exp_done = 1;
        end else begin
            inc = (c_op == 1);
            nd = inc ? 1 : 0;
            allowed = inc ? (MAX_TAP - m_tap) : m_tap;
            if (oor_k >= 1 && oor_k <= c_steps && oor_k <= allowed) begin
                moves = oor_k;
                nt = inc ? m_tap + oor_k - 1 : m_tap - (oor_k - 1);
                no = 1; exp_err = 1;
            end else if (c_steps <= allowed) begin
                moves = c_steps;
                nt = inc ? m_tap + c_steps : m_tap - c_steps;
            end else begin
                moves = allowed;
                nt = inc ? MAX_TAP : 0;
                no = 1; exp_err = 1;
            end
            exp_done = 2 + moves * PER;
        end

        valid = 1'b1; op = c_op[1:0]; steps = c_steps[TAP_W-1:0];
        @(posedge clk); #1;
        for (int c = 1; c <= exp_done; c++) begin
            oor_in = (oor_k > 0) && (c >= 3 + (oor_k - 1) * PER) &&
                     (c <= 2 + (oor_k - 1) * PER + MOVE_GAP);
            op = 2'($urandom);
            steps = 8'($urandom);
            if (c == exp_done) valid = 1'b0;
            exp_mv = (moves > 0 && c >= 2 && ((c - 2) % PER) == 0 && ((c - 2) / PER) < moves) ? 1 : 0;
            exp_ld = (c_op == 0 && c <= LOAD_CYCLES) ? 1 : 0;
            chk("ready_busy", ready, 0);
            chk("move", dl_move, exp_mv);
            chk("load", dl_load, exp_ld);
            chk("dir", dl_dir, nd);
            chk("done", done, (c == exp_done) ? 1 : 0);
            if (c == exp_done) begin
                chk("err", err, exp_err);
                chk("tap", tap, nt);
                chk("oor_err", oor_err, no);
            end
            @(posedge clk); #1;
        end
        oor_in = 1'b0;
        chk("ready_after", ready, 1);
        chk("done_after", done, 0);
        chk("tap_after", tap, nt);
        m_tap = nt; m_oor = no; m_dir = nd;
    endtask

    initial begin
        int r_op, r_steps, r_k;
        // reset state
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_oor", oor_err, 0);
        chk("rst_load", dl_load, 0);
        chk("rst_move", dl_move, 0);
        chk("rst_dir", dl_dir, 0);
        chk("rst_tap", tap, INIT_TAP);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(1, 2, 0);       // INC 2: tap 1 -> 3
        run_cmd(2, 5, 0);       // DEC 5 from 3: saturates at 0
        run_cmd(1, 4, 2);       // INC 4, out-of-range in second gap
        run_cmd(0, 0, 0);       // LOAD clears OOR, tap back to init
        run_cmd(3, 7, 0);       // reserved op
        run_cmd(1, 0, 0);       // zero-step INC
        run_cmd(1, 130, 0);     // climbs to MAX_TAP then pre-check aborts
        run_cmd(1, 1, 0);       // already at MAX_TAP: no move at all
        run_cmd(2, 3, 0);       // DEC from the top
        run_cmd(0, 0, 0);
        run_cmd(2, 1, 0);       // DEC 1 -> 0
        run_cmd(2, 1, 0);       // DEC at 0: immediate abort

        for (int i = 0; i < 40; i++) begin
            r_op = $urandom_range(0, 9);
            r_op = (r_op == 0) ? 0 : (r_op == 1) ? 3 : (r_op < 6) ? 1 : 2;
            r_steps = $urandom_range(0, 9);
            r_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_cmd(r_op, r_steps, r_k);
        end

        // reset in the middle of a long INC, with CMD_VALID held high while busy
        valid = 1'b1; op = 2'b01; steps = 8'd10;
        @(posedge clk); #1;
        for (int c = 1; c < 7; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_gap_move", dl_move, 0);
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_tap", tap, INIT_TAP);
        chk("mid_rst_move", dl_move, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_oor", oor_err, 0);
        chk("mid_rst_dir", dl_dir, 0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("post_rst_move", dl_move, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_ready", ready, 1);
        end
        m_tap = INIT_TAP; m_oor = 0; m_dir = 0;
        run_cmd(1, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
